// File: rtl/crc_arq_ctrl.sv
// Retransmission controller for the CRC link: launches each source word, checks the
// decoder error flag after a fixed latency, retries on error, delivers and counts frames.
module crc_arq_ctrl #(
    parameter int unsigned N         = 16,
    parameter int unsigned LAT       = 1,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] tx_data,
    output logic         tx_launch,
    input  logic [N-1:0] rx_data,
    input  logic         rx_error,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_fail,
    output logic [2:0]   out_retries,
    output logic [15:0]  frames_ok,
    output logic [15:0]  frames_fail
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LAUNCH  = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] CHECK   = 3'd3;
    localparam logic [2:0] DELIVER = 3'd4;

    localparam logic [3:0] LAT_W = 4'(LAT);
    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

    logic [2:0]   state_q, state_d;
    logic [N-1:0] buf_q, buf_d;
    logic [2:0]   tries_q, tries_d;
    logic [3:0]   wait_q, wait_d;
    logic [N-1:0] out_data_q, out_data_d;
    logic         out_fail_q, out_fail_d;
    logic [2:0]   out_retries_q, out_retries_d;
    logic [15:0]  frames_ok_q, frames_ok_d;
    logic [15:0]  frames_fail_q, frames_fail_d;

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        tries_d       = tries_q;
        wait_d        = wait_q;
        out_data_d    = out_data_q;
        out_fail_d    = out_fail_q;
        out_retries_d = out_retries_q;
        frames_ok_d   = frames_ok_q;
        frames_fail_d = frames_fail_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_d   = in_data;
                    tries_d = '0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                wait_d  = LAT_W;
                state_d = WAIT;
            end
            WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_q == 4'd1) state_d = CHECK;
            end
            CHECK: begin
                if (!rx_error) begin
                    out_data_d    = rx_data;
                    out_fail_d    = 1'b0;
                    out_retries_d = tries_q;
                    frames_ok_d   = (frames_ok_q == '1) ? frames_ok_q : frames_ok_q + 16'd1;
                    state_d       = DELIVER;
                end else if (tries_q < MAX_R) begin
                    tries_d = tries_q + 3'd1;
                    state_d = LAUNCH;
                end else begin
                    // Exhausted retries: hand back the untouched source word.
                    out_data_d    = buf_q;
                    out_fail_d    = 1'b1;
                    out_retries_d = tries_q;
                    frames_fail_d = (frames_fail_q == '1) ? frames_fail_q : frames_fail_q + 16'd1;
                    state_d       = DELIVER;
                end
            end
            DELIVER: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            buf_q         <= '0;
            tries_q       <= '0;
            wait_q        <= '0;
            out_data_q    <= '0;
            out_fail_q    <= 1'b0;
            out_retries_q <= '0;
            frames_ok_q   <= '0;
            frames_fail_q <= '0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            tries_q       <= tries_d;
            wait_q        <= wait_d;
            out_data_q    <= out_data_d;
            out_fail_q    <= out_fail_d;
            out_retries_q <= out_retries_d;
            frames_ok_q   <= frames_ok_d;
            frames_fail_q <= frames_fail_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign tx_launch   = (state_q == LAUNCH);
    assign out_valid   = (state_q == DELIVER);
    assign tx_data     = buf_q;
    assign out_data    = out_data_q;
    assign out_fail    = out_fail_q;
    assign out_retries = out_retries_q;
    assign frames_ok   = frames_ok_q;
    assign frames_fail = frames_fail_q;

endmodule

// File: tb/tb_crc_arq_ctrl.sv
// Scoreboard bench for crc_arq_ctrl: a scripted channel injects CRC errors per attempt,
// expected deliveries are queued at accept time and compared at the output handshake.
module tb_crc_arq_ctrl;

    localparam int unsigned N         = 16;
    localparam int unsigned LAT       = 1;
    localparam int unsigned MAX_RETRY = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  tx_data;
    logic          tx_launch;
    logic [N-1:0]  rx_data;
    logic          rx_error;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_fail;
    logic [2:0]    out_retries;
    logic [15:0]   frames_ok;
    logic [15:0]   frames_fail;

    crc_arq_ctrl #(.N(N), .LAT(LAT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx_data(tx_data), .tx_launch(tx_launch),
        .rx_data(rx_data), .rx_error(rx_error),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_fail(out_fail), .out_retries(out_retries),
        .frames_ok(frames_ok), .frames_fail(frames_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        fail;
        logic [2:0]  retries;
        int          rise;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          launches = 0;
    logic [7:0]  err_mask = '0;
    logic [15:0] cur_word = '0;
    int          m_ok = 0;
    int          m_fail = 0;
    logic        ov_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Channel: per-attempt error script; a failed attempt also corrupts the payload.
    always_comb begin
        rx_error = 1'b0;
        if (launches > 0 && launches <= 8) rx_error = err_mask[launches-1];
        rx_data = rx_error ? ~tx_data : tx_data;
    end

    always @(posedge clk) begin
        if (tx_launch) begin
            launches = launches + 1;
            chk("tx_data_at_launch", {16'h0, tx_data}, {16'h0, cur_word});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !ov_prev) begin
            if (sb.size() == 0) chk("spurious_out_valid", {31'h0, out_valid}, 32'h0);
            else                chk("rise_cycle", cyc, sb[0].rise);
        end
        if (out_valid) chk("in_ready_busy", {31'h0, in_ready}, 32'h0);
        if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_data",    {16'h0, out_data},  {16'h0, e.data});
            chk("out_fail",    {31'h0, out_fail},  {31'h0, e.fail});
            chk("out_retries", {29'h0, out_retries}, {29'h0, e.retries});
            chk("launch_count", launches, e.retries + 1);
            if (e.fail) m_fail = (m_fail == 65535) ? m_fail : m_fail + 1;
            else        m_ok   = (m_ok   == 65535) ? m_ok   : m_ok + 1;
            chk("frames_ok",   {16'h0, frames_ok},   m_ok);
            chk("frames_fail", {16'h0, frames_fail}, m_fail);
        end
        ov_prev = out_valid;
    end

    // Called at #1 after a posedge; returns at #1 after the accept edge.
    task automatic send(input logic [15:0] w, input logic [7:0] mask);
        exp_t e;
        int   n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("accept_timeout", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        launches = 0;
        err_mask = mask;
        cur_word = w;
        e.data    = w;
        e.fail    = 1'b1;
        e.retries = 3'(MAX_RETRY);
        for (int unsigned r = 0; r <= MAX_RETRY; r++) begin
            if (!mask[r]) begin
                e.fail    = 1'b0;
                e.retries = 3'(r);
                break;
            end
        end
        e.rise = cyc + (int'(e.retries) + 1) * (LAT + 2);
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  {31'h0, in_ready},  32'h1);
        chk({tag, "_tx_launch"}, {31'h0, tx_launch}, 32'h0);
        chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_out_fail"},  {31'h0, out_fail},  32'h0);
        chk({tag, "_out_data"},  {16'h0, out_data},  32'h0);
        chk({tag, "_retries"},   {29'h0, out_retries}, 32'h0);
        chk({tag, "_tx_data"},   {16'h0, tx_data},   32'h0);
        chk({tag, "_ok"},        {16'h0, frames_ok}, 32'h0);
        chk({tag, "_fail"},      {16'h0, frames_fail}, 32'h0);
    endtask

    initial begin
        int n;
        logic [15:0] held;
        reset     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        send(16'hA5C3, 8'h00);                 // clean channel
        drain();
        send(16'h5A5A, 8'b0000_0011);          // two errors then clean
        drain();
        send(16'h1234, 8'hFF);                 // stuck error
        drain();
        send(16'hBEEF, 8'b0000_0001);
        send(16'hCAFE, 8'h00);                 // back-to-back, source waits for IDLE
        drain();

        // Sink stall with a new word pending on the source side
        out_ready = 1'b0;
        send(16'h0F0F, 8'h00);
        in_data  = 16'h7777;
        in_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_hold_valid", {31'h0, out_valid}, 32'h1);
            chk("stall_hold_data",  {16'h0, out_data}, {16'h0, held});
            chk("stall_in_ready",   {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        send(16'h7777, 8'h00);
        drain();

        // Asynchronous reset while waiting on the channel
        send(16'h4321, 8'h00);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        sb.delete();
        m_ok   = 0;
        m_fail = 0;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(16'h9999, 8'b0000_0001);
        drain();

        // Counter saturation
        force dut.frames_ok_q = 16'hFFFE;
        #1;
        release dut.frames_ok_q;
        m_ok = 16'hFFFE;
        chk("forced_ok", {16'h0, frames_ok}, 32'h0000_FFFE);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            send(16'h1000 + 16'(i), 8'h00);
            drain();
        end
        chk("ok_saturated", {16'h0, frames_ok}, 32'h0000_FFFF);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_arq_ctrl.md
# crc_arq_ctrl

Retransmission controller for the CRC link datapath (crcEncode -> channel/flipper -> crcDecode). It accepts N-bit data words from a source over a valid/ready handshake, launches each word into the encoder, waits a fixed channel latency, and samples the decoder's error flag. On a CRC error it relaunches the same word up to MAX_RETRY more times. It then delivers either the decoded word or a failure-tagged copy of the source word to the sink, and keeps saturating good/failed frame statistics.

## Interface
- N, 16: payload width in bits (matches crcEncode/crcDecode N)
- LAT, 1: cycles from tx_launch to a valid rx_data/rx_error; legal range 1..15
- MAX_RETRY, 3: retransmissions allowed after the first attempt; legal range 0..7
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_data  in  N  source word
- in_valid  in  1  source word valid
- in_ready  out  1  controller can accept a word
- tx_data  out  N  word driven to crcEncode stream input
- tx_launch  out  1  one-cycle strobe: channel sample/inject point for the current attempt
- rx_data  in  N  crcDecode outStream
- rx_error  in  1  crcDecode error
- out_data  out  N  delivered word
- out_valid  out  1  delivered word valid
- out_ready  in  1  sink accepts word
- out_fail  out  1  qualifies out_data: 1 = all attempts failed CRC; out_data is the original source word
- out_retries  out  3  retransmissions used for the delivered word
- frames_ok  out  16  count of words delivered with out_fail=0; saturates at 16'hFFFF
- frames_fail  out  16  count of words delivered with out_fail=1; saturates at 16'hFFFF

## Operation
- FSM states: IDLE, LAUNCH, WAIT, CHECK, DELIVER. All outputs are registered or decoded from state only.
- IDLE: in_ready=1.
  - On in_valid&in_ready: latch in_data into buf, clear tries, go to LAUNCH.
- LAUNCH (1 cycle): tx_launch=1, load wait counter with LAT, go to WAIT.
- WAIT: decrement the counter each cycle. Go to CHECK after exactly LAT cycles in WAIT.
- CHECK (1 cycle): sample rx_error and rx_data.
  - rx_error=0: out_data<=rx_data, out_fail<=0, out_retries<=tries, frames_ok saturating +1, go to DELIVER.
  - rx_error=1 and tries<MAX_RETRY: tries+1, go to LAUNCH.
  - rx_error=1 and tries==MAX_RETRY: out_data<=buf, out_fail<=1, out_retries<=tries, frames_fail saturating +1, go to DELIVER.
- DELIVER: out_valid=1. out_data, out_fail and out_retries are held stable until out_valid&out_ready, then go to IDLE.
- tx_data always equals buf. It is stable for the whole frame, including across retries.
- rx_data and rx_error are ignored outside CHECK.
- in_ready=0 in every state except IDLE. At most one word is in flight, and there is no bypass.
- Counters increment only in CHECK, at the terminal decision, never at the handshake.

## Timing
- Reset (asynchronous assert, synchronous release to IDLE) sets:
  - state=IDLE, in_ready=1
  - tx_launch=0, out_valid=0, out_fail=0
  - out_data=0, out_retries=0, tx_data=0
  - frames_ok=0, frames_fail=0
- Reset mid-frame, in any state: the word is dropped, no out_valid is produced, and counters clear.
- Accept on edge t0. The timeline is:
  - tx_launch high in cycle t0..t0+1
  - CHECK in cycle t0+LAT+1
  - out_valid rises at edge t0+LAT+2
- Each retry adds LAT+2 cycles. Worst case, out_valid rises at t0+(MAX_RETRY+1)(LAT+2).
- Minimum frame period with out_ready held high is LAT+4 cycles (accept -> ... -> DELIVER -> IDLE).
- With out_ready=1 already in the first DELIVER cycle, out_valid is high for exactly 1 cycle.
- in_valid asserted outside IDLE is ignored. The source must hold its word, and it is taken on the first IDLE cycle.
- Saturation: at 16'hFFFF the counter holds its value and does not wrap.

## Test plan
- Clean channel, LAT=1, in_data=16'hA5C3 -> one tx_launch, out_valid at edge t0+3, out_data=16'hA5C3, out_fail=0, out_retries=0, frames_ok=1.
- rx_error=1 on the first 2 CHECKs then 0, MAX_RETRY=3 -> 3 tx_launch pulses with tx_data constant, out_fail=0, out_retries=2, out_valid at t0+9.
- rx_error stuck at 1, in_data=16'h1234 -> 4 launches, out_data=16'h1234, out_fail=1, out_retries=3, frames_fail=1, frames_ok unchanged.
- out_ready=0 for 5 cycles in DELIVER while in_valid=1 with a new word -> out_* stable, in_ready=0, new word accepted only after the out handshake.
- Reset pulled low during WAIT -> all outputs return to their reset values immediately. After release, no out_valid is produced for the dropped word, and the next word completes normally.
- Force frames_ok to 16'hFFFE, then send 3 clean words -> frames_ok reaches 16'hFFFF and holds there.
